pe_decoder: RTL and testbench
=============================

PE_DECODER -- requirements
Module: pe_decoder

Interface
REQ-001 Parameter MAX_FILTERNUM, default 64, SHALL be the number of PEs/filter slots and the width of filter_addr.
REQ-002 Parameter MAX_KERNELNUM, default 8, SHALL be the maximum number of kernels per filter.
REQ-003 Parameter MAX_ROW_NUM, default 8, SHALL be the PE array row count; it is carried for integration and does not affect decoding.
REQ-004 Parameter FILTERNUM_WIDTH, default $clog2(MAX_FILTERNUM)+1 (7), SHALL be the width of the filter-count buses.
REQ-005 Parameter KERNELNUM_WIDTH, default $clog2(MAX_KERNELNUM)+1 (4), SHALL be the width of the kernel-count bus.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 filter_cnt  input  FILTERNUM_WIDTH  SHALL be the index of the filter/PE to load, driven by the controller.
REQ-009 filter_load  input  1  SHALL select the mode: 0 = load (decode active), 1 = compute (no PE selected).
REQ-010 num_filter  input  FILTERNUM_WIDTH  SHALL be the number of filters in use in the PE array.
REQ-011 num_kernel  input  KERNELNUM_WIDTH  SHALL be the number of kernels in use.
REQ-012 filter_addr  output  MAX_FILTERNUM  SHALL be the registered one-hot PE select; bit i selects PE i.

Function
REQ-013 filter_addr SHALL be a register updated on every rising clk edge; latency from inputs to filter_addr is exactly 1 cycle.
REQ-014 Configuration SHALL be valid only when 1 <= num_filter <= MAX_FILTERNUM and 1 <= num_kernel <= MAX_KERNELNUM.
REQ-015 When filter_load = 1, the next filter_addr SHALL be all zeros, regardless of the other inputs.
REQ-016 When filter_load = 0 and the configuration is invalid, the next filter_addr SHALL be all zeros.
REQ-017 When filter_load = 0, the configuration is valid and filter_cnt >= num_filter, the next filter_addr SHALL be all zeros; this covers filter_cnt values above MAX_FILTERNUM-1.
REQ-018 When filter_load = 0, the configuration is valid and filter_cnt < num_filter, the next filter_addr SHALL have only bit filter_cnt set.
REQ-019 filter_addr SHALL never have more than one bit set.
REQ-020 The comparison filter_cnt < num_filter SHALL be unsigned and full-width; no truncation of filter_cnt before the compare.
REQ-021 The block SHALL have no internal counter; consecutive filter_cnt values, including wrap to 0, produce independent decodes each cycle.
REQ-022 A change of filter_load SHALL take effect on the next rising edge; no extra pipeline delay and no handshake.

Reset
REQ-023 While reset = 0, filter_addr SHALL be forced to all zeros immediately, without waiting for a clk edge.
REQ-024 Reset asserted mid-operation SHALL clear filter_addr; after reset is released, the first rising edge SHALL resume normal decoding from the current inputs.
REQ-025 The block SHALL hold no state other than filter_addr.

Verification
REQ-026 Reset scenario: reset = 0 with filter_load = 0 and filter_cnt = 5 -> filter_addr = 0 asynchronously; release reset -> next edge gives filter_addr = 64'h20.
REQ-027 Load sweep: num_filter = 32, num_kernel = 4, filter_load = 0, filter_cnt steps 0..32 then wraps to 0 -> one cycle later filter_addr = 1<<filter_cnt for 0..31, 0 for filter_cnt = 32, then 64'h1 after the wrap.
REQ-028 Compute mode: filter_load = 1 with filter_cnt = 3 -> filter_addr = 0 on the next edge; filter_load returns to 0 -> 64'h8 on the following edge.
REQ-029 Invalid configuration: num_kernel = 0 or 9, or num_filter = 0 or 65, with filter_load = 0 and filter_cnt = 2 -> filter_addr = 0.
REQ-030 Boundary: num_filter = 64, filter_cnt = 63 -> filter_addr = 64'h8000_0000_0000_0000; filter_cnt = 64 or 127 -> 0.
REQ-031 Mid-run reset: reset pulsed low between clk edges during the load sweep -> filter_addr = 0 immediately; one-hot output returns on the first edge after release.

Source files
------------

// File: rtl/pe_decoder.sv
// pe_decoder: registered one-hot PE select for filter loading, cleared in compute mode or on bad configuration.
module pe_decoder #(
  parameter int MAX_FILTERNUM   = 64,
  parameter int MAX_KERNELNUM   = 8,
  parameter int MAX_ROW_NUM     = 8,
  parameter int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
  parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FILTERNUM_WIDTH-1:0] filter_cnt,
  input  logic                       filter_load,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  output logic [MAX_FILTERNUM-1:0]   filter_addr
);
  localparam logic [FILTERNUM_WIDTH-1:0] F_MAX = FILTERNUM_WIDTH'(MAX_FILTERNUM);
  localparam logic [KERNELNUM_WIDTH-1:0] K_MAX = KERNELNUM_WIDTH'(MAX_KERNELNUM);
  localparam logic [MAX_FILTERNUM-1:0]   ONE   = MAX_FILTERNUM'(1);
  if (MAX_ROW_NUM < 1 || MAX_FILTERNUM < 1 || MAX_KERNELNUM < 1) begin : g_bad_params
    $error("pe_decoder: array dimensions must be positive");
  end
  logic                     cfg_ok;
  logic                     hit;
  logic [MAX_FILTERNUM-1:0] next_addr;
  always_comb begin
    cfg_ok    = (|num_filter) && (num_filter <= F_MAX) && (|num_kernel) && (num_kernel <= K_MAX);
    hit       = !filter_load && cfg_ok && (filter_cnt < num_filter);
    next_addr = hit ? ONE << filter_cnt : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) filter_addr <= '0;
    else        filter_addr <= next_addr;
endmodule

// File: tb/tb_pe_decoder.sv
// tb_pe_decoder: directed checks of the PE select decoder against hand-computed one-hot values.
module tb_pe_decoder;
  logic        clk = 0;
  logic        reset = 0;
  logic [6:0]  filter_cnt = 7'd5;
  logic        filter_load = 0;
  logic [6:0]  num_filter = 7'd32;
  logic [3:0]  num_kernel = 4'd4;
  logic [63:0] filter_addr;
  int          n_chk = 0;
  int          n_pass = 0;
  pe_decoder dut (
    .clk(clk), .reset(reset), .filter_cnt(filter_cnt), .filter_load(filter_load),
    .num_filter(num_filter), .num_kernel(num_kernel), .filter_addr(filter_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3 chk("reset_async", filter_addr, 64'h0);
    tick;
    chk("reset_held", filter_addr, 64'h0);
    reset = 1;
    tick;
    chk("reset_release", filter_addr, 64'h20);
    for (int i = 0; i <= 32; i++) begin
      filter_cnt = 7'(i);
      tick;
      chk($sformatf("sweep_%0d", i), filter_addr, i < 32 ? 64'(1) << i : 64'h0);
      if (i == 10) begin
        reset = 0;
        #1 chk("midrun_reset", filter_addr, 64'h0);
        #1 reset = 1;
        tick;
        chk("midrun_resume", filter_addr, 64'h400);
      end
    end
    filter_cnt = 7'd0;
    tick;
    chk("sweep_wrap", filter_addr, 64'h1);
    filter_load = 1;
    filter_cnt = 7'd3;
    tick;
    chk("compute_mode", filter_addr, 64'h0);
    filter_load = 0;
    tick;
    chk("load_return", filter_addr, 64'h8);
    filter_cnt = 7'd2;
    num_kernel = 4'd0;
    tick;
    chk("bad_nk0", filter_addr, 64'h0);
    num_kernel = 4'd9;
    tick;
    chk("bad_nk9", filter_addr, 64'h0);
    num_kernel = 4'd8;
    tick;
    chk("nk8_ok", filter_addr, 64'h4);
    num_filter = 7'd0;
    tick;
    chk("bad_nf0", filter_addr, 64'h0);
    num_filter = 7'd65;
    tick;
    chk("bad_nf65", filter_addr, 64'h0);
    num_filter = 7'd64;
    tick;
    chk("nf64_ok", filter_addr, 64'h4);
    filter_cnt = 7'd63;
    tick;
    chk("cnt63", filter_addr, 64'h8000_0000_0000_0000);
    filter_cnt = 7'd64;
    tick;
    chk("cnt64", filter_addr, 64'h0);
    filter_cnt = 7'd127;
    tick;
    chk("cnt127", filter_addr, 64'h0);
    num_filter = 7'd1;
    filter_cnt = 7'd0;
    tick;
    chk("nf1_cnt0", filter_addr, 64'h1);
    filter_cnt = 7'd1;
    tick;
    chk("nf1_cnt1", filter_addr, 64'h0);
    num_filter = 7'd64;
    filter_cnt = 7'd63;
    filter_load = 1;
    tick;
    chk("compute_cnt63", filter_addr, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
